muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_sign_fix.sv | 17 +
 rtl/muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_muldiv_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operand width, funct3 operation codes and the sequencer state type.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; used both to take operand
// magnitudes and to restore the sign of a result.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  function automatic logic [W-1:0] negate(input logic [W-1:0] v);
    return ~v + {{(W-1){1'b0}}, 1'b1};
  endfunction

  assign res = neg ? negate(val) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide on operand magnitudes, with a one-cycle writeback pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  localparam int DW = 2 * XLEN;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   opnd_q;
  logic [DW-1:0]     prod_q;
  logic              neg_res_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   wb_data_q;
  logic [4:0]        wb_rd_q;

  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic              is_div_in, a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic              accept, last;

  logic [XLEN:0]     mul_sum, div_trial;
  logic [DW-1:0]     prod_nxt, res_raw, res_fix;
  logic [XLEN-1:0]   calc_res;

  // Operand decode and magnitudes, used only in the accepting cycle
  assign rs1_s     = rs1_data;
  assign rs2_s     = rs2_data;
  assign is_div_in = funct3[2];
  assign a_signed  = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                     (funct3 == F3_DIV)  || (funct3 == F3_REM);
  assign b_signed  = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign neg_a     = a_signed && (rs1_s < 0);
  assign neg_b     = b_signed && (rs2_s < 0);

  muldiv_sign_fix #(.W(XLEN)) u_mag_a (.val(rs1_data), .neg(neg_a), .res(mag_a));
  muldiv_sign_fix #(.W(XLEN)) u_mag_b (.val(rs2_data), .neg(neg_b), .res(mag_b));

  assign div_zero = (rs2_data == '0);
  assign div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                    (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
  assign special  = is_div_in && (div_zero || div_ovf);

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = funct3[1] ? rs1_data : '1;
    else
      special_res = funct3[1] ? '0 : rs1_data;
  end

  assign accept = (state_q == S_IDLE) && start && !kill;
  assign last   = (state_q == S_CALC) && (cnt_q == 5'd31);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC:  if (last)   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign busy     = (state_q != S_IDLE);
  assign wb_valid = (state_q == S_DONE) && !kill;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

  // One iteration: prod_q holds {hi, lo} for multiply, {remainder, quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, prod_q[DW-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = {prod_q[DW-1:XLEN], prod_q[XLEN-1]} - {1'b0, opnd_q};
    prod_nxt  = {mul_sum, prod_q[XLEN-1:1]};
    if (op_q[2])
      prod_nxt = div_trial[XLEN] ? {prod_q[DW-2:0], 1'b0}
                                 : {div_trial[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
  end

  // Sign restore is done in 64 bits so one negator serves product, quotient and remainder
  assign res_raw = op_q[2] ? {{XLEN{1'b0}}, (op_q[1] ? prod_nxt[DW-1:XLEN] : prod_nxt[XLEN-1:0])}
                           : prod_nxt;

  muldiv_sign_fix #(.W(DW)) u_res (.val(res_raw), .neg(neg_res_q), .res(res_fix));

  assign calc_res = (op_q[2] || (op_q[1:0] == 2'b00)) ? res_fix[XLEN-1:0] : res_fix[DW-1:XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= '0;
      opnd_q    <= '0;
      prod_q    <= '0;
      neg_res_q <= 1'b0;
      rd_q      <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      op_q      <= funct3;
      rd_q      <= rd_in;
      opnd_q    <= is_div_in ? mag_b : mag_a;
      prod_q    <= {{XLEN{1'b0}}, (is_div_in ? mag_a : mag_b)};
      neg_res_q <= (is_div_in && funct3[1]) ? neg_a : (neg_a ^ neg_b);
      if (special) begin
        wb_data_q <= special_res;
        wb_rd_q   <= rd_in;
      end
    end else if ((state_q == S_CALC) && !kill) begin
      prod_q <= prod_nxt;
      cnt_q  <= cnt_q + 5'd1;
      if (last) begin
        wb_data_q <= calc_res;
        wb_rd_q   <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases, special cases,
// kill/reset aborts, held start and a short randomised run against a model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        busy, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    int          lat;
    int          cyc0;
  } exp_t;

  exp_t sb[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .kill     (kill),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .busy     (busy),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_wb", 64'd1, 64'd0);
      end else begin : pop
        exp_t e;
        e = sb.pop_front();
        chk("wb_data", wb_data, e.data);
        chk("wb_rd", wb_rd, e.rd);
        chk("latency", cyc - e.cyc0, e.lat);
      end
    end
  end

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sp;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[63:32]; end
      3'd2: begin sp = longint'($signed(a)) * longint'({32'b0, b}); return sp[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF)))
      return 1;
    return 33;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat);
    wait_idle();
    @(posedge clk); #1;
    funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
    sb.push_back('{exp, rd, lat, cyc});
    @(posedge clk); #1;
    start = 1'b0;
    rs1_data = $urandom; rs2_data = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
    wait_idle();
  endtask

  task automatic start_untracked(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    @(posedge clk); #1;
    funct3 = f; rs1_data = a; rs2_data = b; rd_in = 5'd17; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; kill = 1'b0;
    funct3 = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    rst_n = 1'b1;

    run_op(3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 33);
    chk("wb_data_hold", wb_data, 32'hFFFFFFEB);
    chk("wb_valid_idle", wb_valid, 0);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 33);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 33);
    run_op(3'd2, 32'hFFFFFFFF, 32'h00000002, 5'd8,  32'hFFFFFFFF, 33);
    run_op(3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd9,  32'hFFFFFFFD, 33);
    run_op(3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd10, 32'hFFFFFFFF, 33);
    run_op(3'd5, 32'd100,      32'd7,        5'd0,  32'd14,       33);
    run_op(3'd7, 32'd100,      32'd7,        5'd11, 32'd2,        33);
    run_op(3'd5, 32'h00001234, 32'h0,        5'd12, 32'hFFFFFFFF, 1);
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000, 1);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1);
    run_op(3'd6, 32'hDEADBEEF, 32'h0,        5'd15, 32'hDEADBEEF, 1);

    start_untracked(3'd0, 32'd5, 32'd6);
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_busy", busy, 0);
    run_op(3'd0, 32'd3, 32'd4, 5'd3, 32'd12, 33);

    start_untracked(3'd4, 32'd1000, 32'd3);
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_wb_valid", wb_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    wait_idle();
    @(posedge clk); #1;
    funct3 = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd21; start = 1'b1;
    sb.push_back('{32'd14, 5'd21, 33, cyc});
    @(posedge clk); #1;
    chk("busy_calc", busy, 1);
    repeat (31) @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op(f, a, b, 5'(i + 1), model(f, a, b), model_lat(f, a, b));
    end

    begin
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
